// File: rtl/barker_pkg.sv
// Shared Barker-11 constants and transmit FSM state type (also used by the correlator).
// Latency: n/a (package).
// Backpressure: n/a (package).
package barker_pkg;

  localparam int BARKER_LEN = 11;
  localparam logic [BARKER_LEN-1:0] BARKER11 = 11'b11100010010;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    GAP
  } tx_state_t;

endpackage

// File: rtl/barker_chip_seq.sv
// Chip counter plus code lookup: walks CODE MSB first, wrapping at the symbol boundary.
// Latency: chip is combinational from the registered index; index steps one cycle after advance.
// Backpressure: index holds whenever advance is low.
//
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset
//   advance       step to the next chip (wraps CODE_LEN-1 -> 0)
//   clear         force the index back to chip 0 (wins over advance)
//   chip          current code chip, CODE[CODE_LEN-1-chip_idx]
//   chip_idx      current chip index
//   wrap          current chip is the last one of the code word
module barker_chip_seq
  import barker_pkg::*;
#(
  parameter int                    CODE_LEN = BARKER_LEN,
  parameter logic [CODE_LEN-1:0]   CODE     = BARKER11,
  parameter int                    IDX_W    = $clog2(CODE_LEN)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             advance,
  input  logic             clear,
  output logic             chip,
  output logic [IDX_W-1:0] chip_idx,
  output logic             wrap
);

  // Bit-reversed copy so chip n can be picked with a plain index.
  logic [CODE_LEN-1:0] code_rev;

  always_comb begin
    code_rev = '0;
    for (int n = 0; n < CODE_LEN; n++) begin
      code_rev[n] = CODE[CODE_LEN-1-n];
    end
  end

  assign chip = code_rev[chip_idx];
  assign wrap = (chip_idx == IDX_W'(CODE_LEN - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      chip_idx <= '0;
    end else if (clear) begin
      chip_idx <= '0;
    end else if (advance) begin
      chip_idx <= wrap ? '0 : chip_idx + 1'b1;
    end
  end

endmodule

// File: rtl/barker_spreader.sv
// Spreads 1-bit AXI-Stream symbols into Barker chips (inverted code for a 0), with a per-frame preamble.
// Latency: first chip valid one cycle after the first symbol of a frame is accepted.
// Backpressure: m_tready low freezes all state; s_tready only opens on the last chip of a symbol.
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   s_tdata/s_tvalid/s_tlast/s_tready   symbol input stream (s_tlast marks end of frame)
//   m_tdata/m_tvalid/m_tready           chip output stream
//   m_tlast             last chip of the last symbol of a frame
//   m_tuser             chip 0 of every data symbol (never during the preamble)
//   o_underrun          one-cycle pulse when a mid-frame symbol boundary found no symbol waiting
module barker_spreader
  import barker_pkg::*;
#(
  parameter int                  CODE_LEN      = BARKER_LEN,
  parameter logic [CODE_LEN-1:0] CODE          = BARKER11,
  parameter int                  PREAMBLE_REPS = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic s_tdata,
  input  logic s_tvalid,
  input  logic s_tlast,
  output logic s_tready,
  output logic m_tdata,
  output logic m_tvalid,
  input  logic m_tready,
  output logic m_tlast,
  output logic m_tuser,
  output logic o_underrun
);

  localparam int IDX_W = $clog2(CODE_LEN);
  // Keep the repetition counter at least one bit wide so REPS=0 still elaborates.
  localparam int REP_W = (PREAMBLE_REPS > 0) ? $clog2(PREAMBLE_REPS + 1) : 1;
  localparam logic [REP_W-1:0] REP_LAST =
    REP_W'((PREAMBLE_REPS > 0) ? PREAMBLE_REPS - 1 : 0);

  tx_state_t        state_q, state_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             sym_q, sym_d;
  logic             last_q, last_d;
  logic             underrun_d;

  logic             advance;
  logic             clear;
  logic             chip;
  logic [IDX_W-1:0] chip_idx;
  logic             wrap;

  barker_chip_seq #(
    .CODE_LEN (CODE_LEN),
    .CODE     (CODE),
    .IDX_W    (IDX_W)
  ) u_chip_seq (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .advance  (advance),
    .clear    (clear),
    .chip     (chip),
    .chip_idx (chip_idx),
    .wrap     (wrap)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      rep_q      <= '0;
      sym_q      <= 1'b0;
      last_q     <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      state_q    <= state_d;
      rep_q      <= rep_d;
      sym_q      <= sym_d;
      last_q     <= last_d;
      o_underrun <= underrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rep_d      = rep_q;
    sym_d      = sym_q;
    last_d     = last_q;
    advance    = 1'b0;
    clear      = 1'b0;
    underrun_d = 1'b0;
    m_tvalid   = 1'b0;
    m_tdata    = 1'b0;
    m_tuser    = 1'b0;
    m_tlast    = 1'b0;
    s_tready   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Reset holds the FSM here; keep the input closed while it is asserted.
        s_tready = !i_rst;
        if (s_tvalid && !i_rst) begin
          sym_d   = s_tdata;
          last_d  = s_tlast;
          rep_d   = '0;
          clear   = 1'b1;
          state_d = (PREAMBLE_REPS > 0) ? PREAMBLE : DATA;
        end
      end

      PREAMBLE: begin
        m_tvalid = 1'b1;
        m_tdata  = chip;
        if (m_tready) begin
          advance = 1'b1;
          if (wrap) begin
            if (rep_q == REP_LAST) begin
              state_d = DATA;
            end else begin
              rep_d = rep_q + 1'b1;
            end
          end
        end
      end

      DATA: begin
        m_tvalid = 1'b1;
        m_tdata  = ~(chip ^ sym_q);
        m_tuser  = (chip_idx == '0);
        m_tlast  = last_q && wrap;
        // Open the input exactly on the boundary handshake so the next symbol follows without a bubble.
        s_tready = wrap && m_tready && !last_q;
        if (m_tready) begin
          advance = 1'b1;
          if (wrap) begin
            if (last_q) begin
              state_d = IDLE;
            end else if (s_tvalid) begin
              sym_d  = s_tdata;
              last_d = s_tlast;
            end else begin
              state_d    = GAP;
              underrun_d = 1'b1;
            end
          end
        end
      end

      GAP: begin
        s_tready = !i_rst;
        if (s_tvalid && !i_rst) begin
          sym_d   = s_tdata;
          last_d  = s_tlast;
          clear   = 1'b1;
          state_d = DATA;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_barker_spreader.sv
module tb_barker_spreader;

  localparam bit [10:0] CODE_W = 11'b11100010010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT with a two-word preamble
  logic s_tdata = 1'b0, s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
  logic m_tdata, m_tvalid, m_tlast, m_tuser, o_underrun;
  logic m_tready = 1'b1;

  // DUT without preamble
  logic s0_tdata = 1'b0, s0_tvalid = 1'b0, s0_tlast = 1'b0, s0_tready;
  logic m0_tdata, m0_tvalid, m0_tlast, m0_tuser, u0_underrun;
  logic m0_tready = 1'b1;

  barker_spreader #(.CODE_LEN(11), .CODE(11'b11100010010), .PREAMBLE_REPS(2)) dut (
    .i_clk(clk), .i_rst(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_tuser(m_tuser), .o_underrun(o_underrun)
  );

  barker_spreader #(.CODE_LEN(11), .CODE(11'b11100010010), .PREAMBLE_REPS(0)) dut0 (
    .i_clk(clk), .i_rst(rst),
    .s_tdata(s0_tdata), .s_tvalid(s0_tvalid), .s_tlast(s0_tlast), .s_tready(s0_tready),
    .m_tdata(m0_tdata), .m_tvalid(m0_tvalid), .m_tready(m0_tready),
    .m_tlast(m0_tlast), .m_tuser(m0_tuser), .o_underrun(u0_underrun)
  );

  int checks = 0;
  int failures = 0;

  // Source: {last, data} items; each item waits dly cycles after reaching the head.
  bit [1:0] src_q[$];
  int       dly_q[$];
  bit       frame_syms[$];
  bit       rand_ready = 1'b0;
  bit       s_fire = 1'b0;

  // Scoreboard
  bit exp_d[$], exp_u[$], exp_l[$];
  bit got_d[$], got_u[$], got_l[$];
  int got_c[$];
  int cyc = 0;
  int underrun_cnt, stall_viol, stall_seen, idle_mid;
  bit in_frame, prev_stall, pd, pu, pl;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Driver: updates inputs just after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (s_fire && src_q.size() > 0) begin
      void'(src_q.pop_front());
      void'(dly_q.pop_front());
    end
    if (dly_q.size() > 0 && dly_q[0] > 0) dly_q[0] = dly_q[0] - 1;
    m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (src_q.size() > 0 && dly_q[0] == 0) begin
      s_tvalid = 1'b1;
      s_tdata  = src_q[0][0];
      s_tlast  = src_q[0][1];
    end else begin
      s_tvalid = 1'b0;
      s_tdata  = 1'b0;
      s_tlast  = 1'b0;
    end
  end

  // Monitor: samples on the falling edge, i.e. the values the next rising edge will see.
  initial forever begin
    @(negedge clk);
    s_fire = s_tvalid && s_tready && !rst;
    if (o_underrun) underrun_cnt++;
    if (prev_stall) begin
      stall_seen++;
      if (!m_tvalid || m_tdata !== pd || m_tuser !== pu || m_tlast !== pl) stall_viol++;
    end
    prev_stall = m_tvalid && !m_tready;
    pd = m_tdata; pu = m_tuser; pl = m_tlast;
    if (m_tvalid && m_tready) begin
      got_d.push_back(m_tdata);
      got_u.push_back(m_tuser);
      got_l.push_back(m_tlast);
      got_c.push_back(cyc);
      in_frame = !m_tlast;
    end else if (in_frame && !m_tvalid) begin
      idle_mid++;
    end
  end

  // Reference model: preamble words, then each symbol as the code (1) or its inverse (0).
  task automatic model_frame(input int reps);
    for (int r = 0; r < reps; r++)
      for (int n = 0; n < 11; n++) begin
        exp_d.push_back(CODE_W[10-n]);
        exp_u.push_back(1'b0);
        exp_l.push_back(1'b0);
      end
    for (int k = 0; k < frame_syms.size(); k++)
      for (int n = 0; n < 11; n++) begin
        exp_d.push_back(frame_syms[k] ? CODE_W[10-n] : !CODE_W[10-n]);
        exp_u.push_back(n == 0);
        exp_l.push_back((k == frame_syms.size() - 1) && (n == 10));
      end
  endtask

  task automatic push_frame(input int reps);
    for (int k = 0; k < frame_syms.size(); k++) begin
      src_q.push_back({bit'(k == frame_syms.size() - 1), frame_syms[k]});
      dly_q.push_back(0);
    end
    model_frame(reps);
  endtask

  task automatic clear_sb();
    exp_d.delete(); exp_u.delete(); exp_l.delete();
    got_d.delete(); got_u.delete(); got_l.delete(); got_c.delete();
    underrun_cnt = 0; stall_viol = 0; stall_seen = 0; idle_mid = 0;
    in_frame = 1'b0; prev_stall = 1'b0;
  endtask

  task automatic wait_chips(input int n, input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (got_d.size() >= n) break;
    end
    if (i == budget) begin
      failures++;
      $display("FAIL %s_timeout got %0d chips, required %0d", name, got_d.size(), n);
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({m_tvalid, m_tdata, m_tlast, m_tuser, s_tready, o_underrun} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs got v/d/l/u/rdy/unr=%b%b%b%b%b%b required 000000",
               m_tvalid, m_tdata, m_tlast, m_tuser, s_tready, o_underrun);
    end
    @(posedge clk); #2; rst = 1'b0;
    @(negedge clk);
    checks++;
    if (s_tready !== 1'b1 || m_tvalid !== 1'b0 || s0_tready !== 1'b1) begin
      failures++;
      $display("FAIL idle_after_reset got s_tready=%b m_tvalid=%b s0_tready=%b required 1 0 1",
               s_tready, m_tvalid, s0_tready);
    end
  endtask

  task automatic test_frame_101();
    clear_sb(); rand_ready = 1'b0;
    frame_syms.delete();
    frame_syms.push_back(1'b1); frame_syms.push_back(1'b0); frame_syms.push_back(1'b1);
    push_frame(2);
    wait_chips(55, 300, "f101");
    checks++;
    if (got_d.size() !== 55) begin
      failures++;
      $display("FAIL f101_count got %0d chips required 55", got_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if ({got_d[i], got_u[i], got_l[i]} !== {exp_d[i], exp_u[i], exp_l[i]}) begin
        failures++;
        $display("FAIL f101_chip[%0d] got d/u/l=%b%b%b required %b%b%b", i,
                 got_d[i], got_u[i], got_l[i], exp_d[i], exp_u[i], exp_l[i]);
      end
    end
    checks++;
    if (got_c.size() == 55 && (got_c[54] - got_c[0]) !== 54) begin
      failures++;
      $display("FAIL f101_contiguous got span %0d cycles required 54", got_c[54] - got_c[0]);
    end
    checks++;
    if (underrun_cnt !== 0) begin
      failures++;
      $display("FAIL f101_underrun got %0d pulses required 0", underrun_cnt);
    end
  endtask

  task automatic test_backpressure();
    clear_sb(); rand_ready = 1'b1;
    frame_syms.delete();
    frame_syms.push_back(1'b1); frame_syms.push_back(1'b0); frame_syms.push_back(1'b1);
    push_frame(2);
    // Back-to-back frames of random length and content after the fixed one.
    for (int f = 0; f < 4; f++) begin
      frame_syms.delete();
      for (int k = 0; k < int'($urandom_range(1, 5)); k++) frame_syms.push_back(1'($urandom_range(0, 1)));
      push_frame(2);
    end
    wait_chips(exp_d.size(), 4000, "bp");
    checks++;
    if (got_d.size() !== exp_d.size()) begin
      failures++;
      $display("FAIL bp_count got %0d chips required %0d", got_d.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if ({got_d[i], got_u[i], got_l[i]} !== {exp_d[i], exp_u[i], exp_l[i]}) begin
        failures++;
        $display("FAIL bp_chip[%0d] got d/u/l=%b%b%b required %b%b%b", i,
                 got_d[i], got_u[i], got_l[i], exp_d[i], exp_u[i], exp_l[i]);
      end
    end
    checks++;
    if (stall_viol !== 0 || stall_seen == 0) begin
      failures++;
      $display("FAIL bp_hold_stable got %0d violations over %0d stalls required 0 over >0",
               stall_viol, stall_seen);
    end
    checks++;
    if (underrun_cnt !== 0) begin
      failures++;
      $display("FAIL bp_underrun got %0d pulses required 0", underrun_cnt);
    end
    rand_ready = 1'b0;
  endtask

  task automatic test_underrun();
    clear_sb(); rand_ready = 1'b0;
    frame_syms.delete();
    frame_syms.push_back(1'b1); frame_syms.push_back(1'($urandom_range(0, 1)));
    push_frame(2);
    // Hold the second symbol back past the end of the first (22 preamble + 11 data chips).
    dly_q[1] = 38;
    wait_chips(44, 300, "ur");
    checks++;
    if (got_d.size() !== 44) begin
      failures++;
      $display("FAIL ur_count got %0d chips required 44 (no second preamble)", got_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if ({got_d[i], got_u[i], got_l[i]} !== {exp_d[i], exp_u[i], exp_l[i]}) begin
        failures++;
        $display("FAIL ur_chip[%0d] got d/u/l=%b%b%b required %b%b%b", i,
                 got_d[i], got_u[i], got_l[i], exp_d[i], exp_u[i], exp_l[i]);
      end
    end
    checks++;
    if (underrun_cnt !== 1) begin
      failures++;
      $display("FAIL ur_pulse got %0d cycles high required 1", underrun_cnt);
    end
    checks++;
    if (idle_mid < 3) begin
      failures++;
      $display("FAIL ur_gap_invalid got %0d mid-frame idle cycles required >=3", idle_mid);
    end
  endtask

  task automatic test_async_reset();
    int i;
    clear_sb(); rand_ready = 1'b0;
    frame_syms.delete();
    frame_syms.push_back(1'b1); frame_syms.push_back(1'b0); frame_syms.push_back(1'b1);
    push_frame(2);
    // 29 chips seen means data chip 6 (stream index 28) is on the bus now.
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (got_d.size() >= 29) break;
    end
    checks++;
    if (i == 300 || m_tvalid !== 1'b1) begin
      failures++;
      $display("FAIL ar_reach_chip6 got %0d chips valid=%b required 29 valid=1", got_d.size(), m_tvalid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({m_tvalid, s_tready, m_tlast, m_tuser} !== 4'b0) begin
      failures++;
      $display("FAIL ar_immediate got v/rdy/l/u=%b%b%b%b required 0000",
               m_tvalid, s_tready, m_tlast, m_tuser);
    end
    src_q.delete(); dly_q.delete(); s_fire = 1'b0;
    repeat (3) @(negedge clk);
    #2; rst = 1'b0;
    clear_sb();
    frame_syms.delete();
    frame_syms.push_back(1'($urandom_range(0, 1)));
    push_frame(2);
    wait_chips(33, 300, "ar");
    checks++;
    if (got_d.size() !== 33) begin
      failures++;
      $display("FAIL ar_restart_count got %0d chips required 33", got_d.size());
    end
    for (int j = 0; j < exp_d.size() && j < got_d.size(); j++) begin
      checks++;
      if ({got_d[j], got_u[j], got_l[j]} !== {exp_d[j], exp_u[j], exp_l[j]}) begin
        failures++;
        $display("FAIL ar_chip[%0d] got d/u/l=%b%b%b required %b%b%b", j,
                 got_d[j], got_u[j], got_l[j], exp_d[j], exp_u[j], exp_l[j]);
      end
    end
  endtask

  task automatic test_reps0();
    @(posedge clk); #1;
    s0_tvalid = 1'b1; s0_tdata = 1'b0; s0_tlast = 1'b1; m0_tready = 1'b1;
    @(negedge clk);
    checks++;
    if (s0_tready !== 1'b1) begin
      failures++;
      $display("FAIL r0_accept got s_tready=%b required 1", s0_tready);
    end
    @(posedge clk); #1;
    s0_tvalid = 1'b0; s0_tlast = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      checks++;
      if ({m0_tvalid, m0_tdata, m0_tuser, m0_tlast} !== {1'b1, !CODE_W[10-i], i == 0, i == 10}) begin
        failures++;
        $display("FAIL r0_chip[%0d] got v/d/u/l=%b%b%b%b required %b%b%b%b", i,
                 m0_tvalid, m0_tdata, m0_tuser, m0_tlast, 1'b1, !CODE_W[10-i], i == 0, i == 10);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (m0_tvalid !== 1'b0 || s0_tready !== 1'b1) begin
      failures++;
      $display("FAIL r0_idle got m_tvalid=%b s_tready=%b required 0 1", m0_tvalid, s0_tready);
    end
  endtask

  initial begin
    clear_sb();
    test_reset();
    test_frame_101();
    test_backpressure();
    test_underrun();
    test_async_reset();
    test_reps0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
